// File: rtl/uop_sequencer_pkg.sv
// Shared micro-op definitions for the curve arithmetic sequencer: opcodes,
// operand codes, exec conditions, word layout, program selects and FSM states.
package uop_sequencer_pkg;

  localparam int ADDR_W = 6;
  localparam int UOP_W  = 20;
  localparam int PROG_W = 2;

  localparam logic [3:0] OPCODE_CMP = 4'h1;
  localparam logic [3:0] OPCODE_MOV = 4'h2;
  localparam logic [3:0] OPCODE_MUL = 4'h3;
  localparam logic [3:0] OPCODE_ADD = 4'h4;
  localparam logic [3:0] OPCODE_SUB = 4'h5;
  localparam logic [3:0] OPCODE_RDY = 4'hF;

  localparam logic [3:0] UOP_SRC_ZERO = 4'h0;
  localparam logic [3:0] UOP_SRC_PX   = 4'h1;
  localparam logic [3:0] UOP_SRC_PY   = 4'h2;
  localparam logic [3:0] UOP_SRC_PZ   = 4'h3;
  localparam logic [3:0] UOP_SRC_T1   = 4'h4;
  localparam logic [3:0] UOP_SRC_T2   = 4'h5;
  localparam logic [3:0] UOP_DST_T1   = 4'h4;
  localparam logic [3:0] UOP_DST_T2   = 4'h5;
  localparam logic [3:0] UOP_DST_RX   = 4'h6;
  localparam logic [3:0] UOP_DST_RY   = 4'h7;
  localparam logic [3:0] UOP_DST_NONE = 4'hF;

  localparam logic [3:0] UOP_EXEC_ALWAYS     = 4'h0;
  localparam logic [3:0] UOP_EXEC_PZT1T2_0XX = 4'h1;

  localparam int OPCODE_LSB = 16;
  localparam int SRC1_LSB   = 12;
  localparam int SRC2_LSB   = 8;
  localparam int DST_LSB    = 4;
  localparam int EXEC_LSB   = 0;

  localparam logic [PROG_W-1:0] PROG_CONV = 2'd0;
  localparam logic [PROG_W-1:0] PROG_DBL  = 2'd1;
  localparam logic [PROG_W-1:0] PROG_ADD  = 2'd2;
  localparam logic [PROG_W-1:0] PROG_RSVD = 2'd3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_ISSUE  = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] dst;
    logic [3:0] exec;
  } uop_t;

  // Unknown exec codes are treated as never-true so stray ROM words get skipped.
  function automatic logic exec_ok(input logic [3:0] exec, input logic flag_f);
    logic ok;
    ok = 1'b0;
    if (exec == UOP_EXEC_ALWAYS) ok = 1'b1;
    else if (exec == UOP_EXEC_PZT1T2_0XX) ok = flag_f;
    return ok;
  endfunction

endpackage

// File: rtl/uop_sequencer_if.sv
// Control, ROM and datapath handshake bundle between the sequencer (master)
// and its surroundings (slave).
interface uop_sequencer_if;
  import uop_sequencer_pkg::*;

  logic              start;
  logic [PROG_W-1:0] prog_sel;
  logic              busy;
  logic              done;
  logic              err;
  logic [PROG_W-1:0] rom_sel;
  logic [ADDR_W-1:0] rom_addr;
  logic [UOP_W-1:0]  rom_data;
  logic              uop_valid;
  logic [3:0]        uop_opcode;
  logic [3:0]        uop_src1;
  logic [3:0]        uop_src2;
  logic [3:0]        uop_dst;
  logic              uop_done;
  logic              cmp_eq;

  modport master (
    input  start, prog_sel, rom_data, uop_done, cmp_eq,
    output busy, done, err, rom_sel, rom_addr,
           uop_valid, uop_opcode, uop_src1, uop_src2, uop_dst
  );

  modport slave (
    output start, prog_sel, rom_data, uop_done, cmp_eq,
    input  busy, done, err, rom_sel, rom_addr,
           uop_valid, uop_opcode, uop_src1, uop_src2, uop_dst
  );

endinterface

// File: rtl/uop_sequencer.sv
// Microprogram engine: fetches 20-bit micro-ops from a registered ROM, filters
// them on their exec condition and issues them to the datapath one at a time.
module uop_sequencer
  import uop_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  uop_sequencer_if.master  bus
);

  logic [2:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [PROG_W-1:0] sel;
  logic              err_q;
  logic              flag_f;
  logic [3:0]        opcode_q;
  logic [3:0]        src1_q;
  logic [3:0]        src2_q;
  logic [3:0]        dst_q;
  uop_t              word;
  logic              pc_last;

  assign word    = uop_t'(bus.rom_data);
  assign pc_last = &pc;

  // A PC increment out of the last address means the program had no RDY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= '0;
      sel      <= '0;
      err_q    <= 1'b0;
      flag_f   <= 1'b0;
      opcode_q <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      dst_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            sel <= bus.prog_sel;
            pc  <= '0;
            if (bus.prog_sel == PROG_RSVD) begin
              err_q <= 1'b1;
              state <= ST_FINISH;
            end else begin
              err_q <= 1'b0;
              state <= ST_FETCH;
            end
          end
        end
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          if (word.opcode == OPCODE_RDY) begin
            state <= ST_FINISH;
          end else if (!exec_ok(word.exec, flag_f)) begin
            pc <= pc + 1'b1;
            if (pc_last) begin
              err_q <= 1'b1;
              state <= ST_FINISH;
            end else begin
              state <= ST_FETCH;
            end
          end else begin
            opcode_q <= word.opcode;
            src1_q   <= word.src1;
            src2_q   <= word.src2;
            dst_q    <= word.dst;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (bus.uop_done) begin
            if (opcode_q == OPCODE_CMP) flag_f <= bus.cmp_eq;
            pc <= pc + 1'b1;
            if (pc_last) begin
              err_q <= 1'b1;
              state <= ST_FINISH;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy       = (state == ST_FETCH) || (state == ST_DECODE) ||
                          (state == ST_ISSUE) || (state == ST_WAIT);
  assign bus.done       = (state == ST_FINISH);
  assign bus.uop_valid  = (state == ST_ISSUE);
  assign bus.err        = err_q;
  assign bus.rom_sel    = sel;
  assign bus.rom_addr   = pc;
  assign bus.uop_opcode = opcode_q;
  assign bus.uop_src1   = src1_q;
  assign bus.uop_src2   = src2_q;
  assign bus.uop_dst    = dst_q;

endmodule

// File: tb/tb_uop_sequencer.sv
// Directed bench for uop_sequencer: registered ROM model, delayed datapath
// responder and per-scenario tasks with hand-computed expectations.
module tb_uop_sequencer;
  import uop_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  uop_sequencer_if bus ();

  uop_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [19:0] rom [0:3][0:63];

  always @(posedge clk) bus.rom_data <= rom[bus.rom_sel][bus.rom_addr];

  // Monitor: log every issued op and count done/busy cycles.
  int          valid_cnt = 0;
  int          done_cnt = 0;
  int          busy_cnt = 0;
  logic [5:0]  issued_addr [0:255];
  logic [15:0] issued_op   [0:255];
  int          issued_cyc  [0:255];

  always @(negedge clk) begin
    if (bus.uop_valid && valid_cnt < 256) begin
      issued_addr[valid_cnt] <= bus.rom_addr;
      issued_op[valid_cnt]   <= {bus.uop_opcode, bus.uop_src1, bus.uop_src2, bus.uop_dst};
      issued_cyc[valid_cnt]  <= cyc;
      valid_cnt              <= valid_cnt + 1;
    end
    if (bus.done) done_cnt <= done_cnt + 1;
    if (bus.busy) busy_cnt <= busy_cnt + 1;
  end

  // Datapath responder: uop_done resp_delay negedges after the valid is seen.
  int   resp_delay = 2;
  logic cmp_value = 1'b0;

  initial begin
    logic [3:0] op;
    bus.uop_done = 1'b0;
    bus.cmp_eq   = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.uop_valid) begin
        op = bus.uop_opcode;
        repeat (resp_delay) @(negedge clk);
        bus.cmp_eq   = (op == OPCODE_CMP) ? cmp_value : 1'b0;
        bus.uop_done = 1'b1;
        @(negedge clk);
        bus.uop_done = 1'b0;
        bus.cmp_eq   = 1'b0;
      end
    end
  end

  function automatic logic [19:0] mk(input logic [3:0] op, input logic [3:0] s1,
                                     input logic [3:0] s2, input logic [3:0] d,
                                     input logic [3:0] ex);
    return {op, s1, s2, d, ex};
  endfunction

  task automatic start_prog(input logic [1:0] p);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.prog_sel = p;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic wait_done(input int limit, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%0b exp=0", bus.done); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got=%0b exp=0", bus.err); end
    checks++; if (bus.uop_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%0b exp=0", bus.uop_valid); end
    checks++; if (bus.rom_addr !== 6'd0) begin errors++; $display("[TB] FAIL reset_addr got=%0d exp=0", bus.rom_addr); end
    checks++; if (bus.rom_sel !== 2'd0) begin errors++; $display("[TB] FAIL reset_sel got=%0d exp=0", bus.rom_sel); end
    checks++; if ({bus.uop_opcode, bus.uop_src1, bus.uop_src2, bus.uop_dst} !== 16'h0)
      begin errors++; $display("[TB] FAIL reset_fields got=%h exp=0000", {bus.uop_opcode, bus.uop_src1, bus.uop_src2, bus.uop_dst}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_conv_pz_nonzero;
    int vb, db;
    logic seen;
    logic [3:0] exp_op [0:5];
    exp_op = '{OPCODE_CMP, OPCODE_MOV, OPCODE_MUL, OPCODE_MUL, OPCODE_MUL, OPCODE_MUL};
    resp_delay = 2; cmp_value = 1'b0;
    vb = valid_cnt; db = done_cnt;
    start_prog(PROG_CONV);
    wait_done(400, seen);
    repeat (3) @(negedge clk);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL conv1_done_seen got=%0b exp=1", seen); end
    checks++; if (valid_cnt - vb !== 6) begin errors++; $display("[TB] FAIL conv1_ops got=%0d exp=6", valid_cnt - vb); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (issued_addr[vb+k] !== 6'(k)) begin errors++; $display("[TB] FAIL conv1_addr%0d got=%0d exp=%0d", k, issued_addr[vb+k], k); end
      checks++; if (issued_op[vb+k][15:12] !== exp_op[k]) begin errors++; $display("[TB] FAIL conv1_op%0d got=%h exp=%h", k, issued_op[vb+k][15:12], exp_op[k]); end
    end
    checks++; if (done_cnt - db !== 1) begin errors++; $display("[TB] FAIL conv1_done_cnt got=%0d exp=1", done_cnt - db); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL conv1_err got=%0b exp=0", bus.err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL conv1_busy got=%0b exp=0", bus.busy); end
  endtask

  task automatic test_conv_pz_zero;
    int vb, db;
    logic seen;
    resp_delay = 2; cmp_value = 1'b1;
    vb = valid_cnt; db = done_cnt;
    start_prog(PROG_CONV);
    wait_done(400, seen);
    repeat (3) @(negedge clk);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL conv0_done_seen got=%0b exp=1", seen); end
    checks++; if (valid_cnt - vb !== 8) begin errors++; $display("[TB] FAIL conv0_ops got=%0d exp=8", valid_cnt - vb); end
    checks++; if (issued_addr[vb+6] !== 6'd6) begin errors++; $display("[TB] FAIL conv0_addr6 got=%0d exp=6", issued_addr[vb+6]); end
    checks++; if (issued_op[vb+6] !== {OPCODE_MOV, UOP_SRC_ZERO, UOP_SRC_ZERO, UOP_DST_RX})
      begin errors++; $display("[TB] FAIL conv0_op6 got=%h exp=%h", issued_op[vb+6], {OPCODE_MOV, UOP_SRC_ZERO, UOP_SRC_ZERO, UOP_DST_RX}); end
    checks++; if (issued_op[vb+7] !== {OPCODE_MOV, UOP_SRC_ZERO, UOP_SRC_ZERO, UOP_DST_RY})
      begin errors++; $display("[TB] FAIL conv0_op7 got=%h exp=%h", issued_op[vb+7], {OPCODE_MOV, UOP_SRC_ZERO, UOP_SRC_ZERO, UOP_DST_RY}); end
    checks++; if (done_cnt - db !== 1) begin errors++; $display("[TB] FAIL conv0_done_cnt got=%0d exp=1", done_cnt - db); end
  endtask

  task automatic test_back_to_back;
    int vb, db;
    logic seen;
    resp_delay = 1; cmp_value = 1'b0;
    vb = valid_cnt; db = done_cnt;
    start_prog(PROG_ADD);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.prog_sel = PROG_RSVD;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(400, seen);
    repeat (3) @(negedge clk);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done_seen got=%0b exp=1", seen); end
    checks++; if (valid_cnt - vb !== 4) begin errors++; $display("[TB] FAIL b2b_ops got=%0d exp=4", valid_cnt - vb); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (issued_cyc[vb+k+1] - issued_cyc[vb+k] !== 4)
        begin errors++; $display("[TB] FAIL b2b_gap%0d got=%0d exp=4", k, issued_cyc[vb+k+1] - issued_cyc[vb+k]); end
    end
    checks++; if (issued_op[vb+1][15:12] !== OPCODE_SUB) begin errors++; $display("[TB] FAIL b2b_op1 got=%h exp=%h", issued_op[vb+1][15:12], OPCODE_SUB); end
    checks++; if (done_cnt - db !== 1) begin errors++; $display("[TB] FAIL b2b_done_cnt got=%0d exp=1", done_cnt - db); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL b2b_err got=%0b exp=0", bus.err); end
    checks++; if (bus.rom_sel !== PROG_ADD) begin errors++; $display("[TB] FAIL b2b_sel got=%0d exp=%0d", bus.rom_sel, PROG_ADD); end
  endtask

  task automatic test_pc_wrap;
    int vb, db;
    logic seen;
    resp_delay = 1; cmp_value = 1'b0;
    vb = valid_cnt; db = done_cnt;
    start_prog(PROG_DBL);
    wait_done(1000, seen);
    repeat (3) @(negedge clk);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL wrap_done_seen got=%0b exp=1", seen); end
    checks++; if (valid_cnt - vb !== 64) begin errors++; $display("[TB] FAIL wrap_ops got=%0d exp=64", valid_cnt - vb); end
    checks++; if (issued_addr[vb+63] !== 6'd63) begin errors++; $display("[TB] FAIL wrap_last_addr got=%0d exp=63", issued_addr[vb+63]); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL wrap_err got=%0b exp=1", bus.err); end
    checks++; if (done_cnt - db !== 1) begin errors++; $display("[TB] FAIL wrap_done_cnt got=%0d exp=1", done_cnt - db); end
    vb = valid_cnt;
    start_prog(PROG_CONV);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL wrap_err_clear got=%0b exp=0", bus.err); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL wrap_rerun_busy got=%0b exp=1", bus.busy); end
    wait_done(400, seen);
    repeat (3) @(negedge clk);
    checks++; if (valid_cnt - vb !== 6) begin errors++; $display("[TB] FAIL wrap_rerun_ops got=%0d exp=6", valid_cnt - vb); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL wrap_rerun_err got=%0b exp=0", bus.err); end
  endtask

  task automatic test_reserved;
    int vb, db, bb;
    logic seen;
    vb = valid_cnt; db = done_cnt; bb = busy_cnt;
    start_prog(PROG_RSVD);
    wait_done(20, seen);
    repeat (3) @(negedge clk);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL rsvd_done_seen got=%0b exp=1", seen); end
    checks++; if (done_cnt - db !== 1) begin errors++; $display("[TB] FAIL rsvd_done_cnt got=%0d exp=1", done_cnt - db); end
    checks++; if (busy_cnt - bb !== 0) begin errors++; $display("[TB] FAIL rsvd_busy_cycles got=%0d exp=0", busy_cnt - bb); end
    checks++; if (valid_cnt - vb !== 0) begin errors++; $display("[TB] FAIL rsvd_ops got=%0d exp=0", valid_cnt - vb); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL rsvd_err got=%0b exp=1", bus.err); end
  endtask

  task automatic test_reset_midrun;
    int vb, db;
    logic reached;
    resp_delay = 5; cmp_value = 1'b0;
    vb = valid_cnt; db = done_cnt;
    reached = 1'b0;
    start_prog(PROG_CONV);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid_cnt - vb >= 2) begin
        reached = 1'b1;
        break;
      end
    end
    checks++; if (reached !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_reach_wait got=%0b exp=1", reached); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.uop_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid got=%0b exp=0", bus.uop_valid); end
    checks++; if (bus.rom_addr !== 6'd0) begin errors++; $display("[TB] FAIL rstmid_addr got=%0d exp=0", bus.rom_addr); end
    checks++; if (bus.uop_opcode !== 4'd0) begin errors++; $display("[TB] FAIL rstmid_opcode got=%h exp=0", bus.uop_opcode); end
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_stray_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.rom_addr !== 6'd0) begin errors++; $display("[TB] FAIL rstmid_stray_addr got=%0d exp=0", bus.rom_addr); end
    checks++; if (valid_cnt - vb !== 2) begin errors++; $display("[TB] FAIL rstmid_stray_ops got=%0d exp=2", valid_cnt - vb); end
    checks++; if (done_cnt - db !== 0) begin errors++; $display("[TB] FAIL rstmid_stray_done got=%0d exp=0", done_cnt - db); end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.prog_sel = 2'd0;
    for (int p = 0; p < 4; p++)
      for (int a = 0; a < 64; a++)
        rom[p][a] = 20'h0;
    rom[0][0] = mk(OPCODE_CMP, UOP_SRC_PZ, UOP_SRC_ZERO, UOP_DST_NONE, UOP_EXEC_ALWAYS);
    rom[0][1] = mk(OPCODE_MOV, UOP_SRC_PX, UOP_SRC_ZERO, UOP_DST_RX, UOP_EXEC_ALWAYS);
    rom[0][2] = mk(OPCODE_MUL, UOP_SRC_PZ, UOP_SRC_PZ, UOP_DST_T1, UOP_EXEC_ALWAYS);
    rom[0][3] = mk(OPCODE_MUL, UOP_SRC_T1, UOP_SRC_PZ, UOP_DST_T2, UOP_EXEC_ALWAYS);
    rom[0][4] = mk(OPCODE_MUL, UOP_SRC_PX, UOP_SRC_T1, UOP_DST_RX, UOP_EXEC_ALWAYS);
    rom[0][5] = mk(OPCODE_MUL, UOP_SRC_PY, UOP_SRC_T2, UOP_DST_RY, UOP_EXEC_ALWAYS);
    rom[0][6] = mk(OPCODE_MOV, UOP_SRC_ZERO, UOP_SRC_ZERO, UOP_DST_RX, UOP_EXEC_PZT1T2_0XX);
    rom[0][7] = mk(OPCODE_MOV, UOP_SRC_ZERO, UOP_SRC_ZERO, UOP_DST_RY, UOP_EXEC_PZT1T2_0XX);
    rom[0][8] = mk(OPCODE_RDY, 4'h0, 4'h0, 4'h0, UOP_EXEC_ALWAYS);
    for (int a = 0; a < 64; a++)
      rom[1][a] = mk(OPCODE_MOV, UOP_SRC_PX, UOP_SRC_ZERO, UOP_DST_RX, UOP_EXEC_ALWAYS);
    rom[2][0] = mk(OPCODE_ADD, UOP_SRC_PX, UOP_SRC_PY, UOP_DST_T1, UOP_EXEC_ALWAYS);
    rom[2][1] = mk(OPCODE_SUB, UOP_SRC_T1, UOP_SRC_PZ, UOP_DST_T2, UOP_EXEC_ALWAYS);
    rom[2][2] = mk(OPCODE_MUL, UOP_SRC_T1, UOP_SRC_T2, UOP_DST_RX, UOP_EXEC_ALWAYS);
    rom[2][3] = mk(OPCODE_MOV, UOP_SRC_T2, UOP_SRC_ZERO, UOP_DST_RY, UOP_EXEC_ALWAYS);
    rom[2][4] = mk(OPCODE_RDY, 4'h0, 4'h0, 4'h0, UOP_EXEC_ALWAYS);

    test_reset();
    test_conv_pz_nonzero();
    test_conv_pz_zero();
    test_back_to_back();
    test_pc_wrap();
    test_reserved();
    test_reset_midrun();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
